// File: rtl/mod_enc_pkg.sv
// Shared constants, FSM state type and byte-offset helper for the SubBytes sequencer.
package mod_enc_pkg;

  localparam int NBYTES = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} subbytes_state_t;

  // MSB bit position of byte i; byte 0 sits in the top bits (FIPS-197 order).
  function automatic int byte_off(input int i, input int nbytes, input int bw);
    return nbytes * bw - 1 - bw * i;
  endfunction

endpackage

// File: rtl/mod_enc_rom256.sv
// AES forward S-box, 256 x 8, one-cycle registered read (output register not reset).
module mod_enc_rom256 (
  input  logic       clk,
  input  logic [7:0] addr_romSbox,
  output logic [7:0] outp_romSbox
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 is the most significant byte of the packed table.
  logic [7:0] rev_idx;
  assign rev_idx = ~addr_romSbox;

  always_ff @(posedge clk) begin
    outp_romSbox <= SBOX[{rev_idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/mod_enc_subbytes_seq.sv
// SubBytes sequencer: streams 16 state bytes through one shared S-box ROM and
// hands the substituted block downstream over a valid/ready handshake.
module mod_enc_subbytes_seq #(
  parameter int NBYTES = 16,
  parameter int BYTE_W = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NBYTES*BYTE_W-1:0] in_state,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NBYTES*BYTE_W-1:0] out_state,
  output logic                     busy
);

  import mod_enc_pkg::*;

  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  subbytes_state_t state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [BYTE_W-1:0] addr_q, addr_d;
  logic              wr_v_q;
  logic [CW-1:0]     wr_idx_q;
  logic [BYTE_W-1:0] rom_dout;
  logic              accept;

  logic [BYTE_W-1:0] in_bytes [NBYTES];
  logic [BYTE_W-1:0] src_q    [NBYTES];
  logic [BYTE_W-1:0] res_q    [NBYTES];

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign in_bytes[gi] = in_state[byte_off(gi, NBYTES, BYTE_W) -: BYTE_W];
      assign out_state[byte_off(gi, NBYTES, BYTE_W) -: BYTE_W] = res_q[gi];
    end
  endgenerate

  assign cnt_inc   = cnt_q + 1'b1;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // The address register is loaded one step ahead so byte k is on the ROM
  // while cnt_q == k; outside ISSUE it rests at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = '0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
          cnt_d   = '0;
          addr_d  = in_bytes[0];
        end
      end
      ISSUE: begin
        if (cnt_q == LAST) begin
          state_d = DRAIN;
        end else begin
          cnt_d  = cnt_inc;
          addr_d = src_q[cnt_inc];
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wr_v_q   <= 1'b0;
      wr_idx_q <= '0;
      for (int i = 0; i < NBYTES; i++) begin
        src_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_v_q   <= (state_q == ISSUE);
      wr_idx_q <= cnt_q;
      if (accept) begin
        for (int i = 0; i < NBYTES; i++) src_q[i] <= in_bytes[i];
      end
      if (wr_v_q) res_q[wr_idx_q] <= rom_dout;
    end
  end

  mod_enc_rom256 u_sbox (
    .clk          (clk),
    .addr_romSbox (addr_q),
    .outp_romSbox (rom_dout)
  );

endmodule

// File: tb/tb_mod_enc_subbytes_seq.sv
// Directed bench for the SubBytes sequencer: FIPS vector, byte order, backpressure,
// back-to-back throughput, mid-operation reset and input stability.
module tb_mod_enc_subbytes_seq;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  localparam logic [127:0] V1_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_enc_subbytes_seq dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 1.
  task automatic send(input logic [127:0] s);
    in_state = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles since the accept edge until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int t [3];
    logic [127:0] held;
    logic [127:0] blk_in  [3];
    logic [127:0] blk_out [3];

    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_state", out_state, 128'd0);

    // 1. FIPS vector, latency and single-cycle out_valid
    send(V1_IN);
    chk("t1_busy", {127'd0, busy}, 128'd1);
    chk("t1_in_ready", {127'd0, in_ready}, 128'd0);
    wait_valid(lat);
    chk("t1_latency", 128'(lat), 128'd18);
    chk("t1_out", out_state, V1_OUT);
    @(negedge clk);
    chk("t1_valid_drop", {127'd0, out_valid}, 128'd0);
    chk("t1_idle", {127'd0, in_ready}, 128'd1);
    $display("txn fips in=%h out=%h lat=%0d", V1_IN, out_state, lat);

    // 2. Byte ordering
    send(128'h01000000000000000000000000000000);
    wait_valid(lat);
    chk("t2_msb", out_state, 128'h7c636363636363636363636363636363);
    $display("txn order_msb out=%h", out_state);
    @(negedge clk);
    send(128'h00000000000000000000000000000001);
    wait_valid(lat);
    chk("t2_lsb", out_state, 128'h6363636363636363636363636363637c);
    $display("txn order_lsb out=%h", out_state);
    @(negedge clk);

    // 3. Backpressure
    out_ready = 1'b0;
    send(V1_IN);
    wait_valid(lat);
    held = out_state;
    chk("t3_out", held, V1_OUT);
    in_valid = 1'b1;
    in_state = 128'hffffffffffffffffffffffffffffffff;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_valid_hold", {127'd0, out_valid}, 128'd1);
      chk("t3_state_hold", out_state, V1_OUT);
      chk("t3_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_valid", {127'd0, out_valid}, 128'd0);
    chk("t3_release_busy", {127'd0, busy}, 128'd0);
    chk("t3_release_ready", {127'd0, in_ready}, 128'd1);
    $display("txn backpressure out=%h", held);

    // 4. Back-to-back with in_valid and out_ready high
    blk_in[0] = V1_IN;         blk_out[0] = V1_OUT;
    blk_in[1] = 128'h0;        blk_out[1] = {16{8'h63}};
    blk_in[2] = {16{8'hff}};   blk_out[2] = {16{8'h16}};
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      while (in_ready !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      in_state = blk_in[k];
      t[k] = cyc;
      @(negedge clk);
      if (k == 2) in_valid = 1'b0;
      wait_valid(lat);
      chk("t4_out", out_state, blk_out[k]);
      $display("txn b2b%0d in=%h out=%h", k, blk_in[k], out_state);
    end
    chk("t4_gap01", 128'(t[1] - t[0]), 128'd19);
    chk("t4_gap12", 128'(t[2] - t[1]), 128'd19);
    @(negedge clk);

    // 5. Reset during ISSUE at issue_cnt = 7
    send(V1_IN);
    repeat (7) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("t5_busy", {127'd0, busy}, 128'd0);
    chk("t5_ready", {127'd0, in_ready}, 128'd1);
    chk("t5_valid", {127'd0, out_valid}, 128'd0);
    chk("t5_state", out_state, 128'd0);
    @(negedge clk);
    chk("t5_no_stale", out_state, 128'd0);
    send(128'h000102030405060708090a0b0c0d0e0f);
    wait_valid(lat);
    chk("t5_after", out_state, 128'h637c777bf26b6fc53001672bfed7ab76);
    $display("txn after_reset out=%h", out_state);
    @(negedge clk);

    // 6. Input changes after the accept edge are ignored
    send(V1_IN);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      lat++;
    end
    chk("t6_latency", 128'(lat), 128'd18);
    chk("t6_out", out_state, V1_OUT);
    $display("txn stability out=%h", out_state);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
